// File: rtl/raycast_pkg.sv
// Shared types for the raycaster column back end.
// Result bundle, draw FSM states, default screen height.
package raycast_pkg;

  localparam int SCREEN_HEIGHT_DEF = 600;

  typedef struct packed {
    logic [7:0] color;
    logic [9:0] height;
    logic       y_side;
    logic [9:0] column_id;
  } column_result_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2
  } state_t;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO of finished column results.
// A push is visible to pop from the following cycle.
module result_fifo
  import raycast_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  column_result_t din,
  input  logic           pop,
  output column_result_t dout,
  output logic           full,
  output logic           empty,
  output logic [AW:0]    count
);

  column_result_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + {{AW{1'b0}}, do_push}
             - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/column_drawer.sv
// Expands buffered column results into framebuffer
// pixel writes: ceiling, wall, floor, one per cycle.
module column_drawer
  import raycast_pkg::*;
#(
  parameter int         SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int         FIFO_DEPTH    = 4,
  parameter logic [7:0] CEIL_COLOR    = 8'h11,
  parameter logic [7:0] FLOOR_COLOR   = 8'h22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_color,
  input  logic [9:0] in_height,
  input  logic       in_y_side,
  input  logic [9:0] in_column_id,
  output logic       fb_we,
  input  logic       fb_ready,
  output logic [9:0] fb_x,
  output logic [9:0] fb_y,
  output logic [7:0] fb_data,
  output logic       col_done,
  output logic [9:0] col_done_id,
  output logic       overflow,
  output logic       busy
);

  localparam int         AW   = $clog2(FIFO_DEPTH);
  localparam logic [9:0] SH   = 10'(SCREEN_HEIGHT);
  localparam logic [9:0] LAST = 10'(SCREEN_HEIGHT - 1);

  state_t         state;
  state_t         nstate;
  column_result_t in_res;
  column_result_t head;
  column_result_t cur;
  logic           f_full;
  logic           f_empty;
  logic [AW:0]    f_count;
  logic           pop;
  logic           draw;
  logic           accept;
  logic           last_acc;
  logic [9:0]     row;
  logic [9:0]     top_r;
  logic [9:0]     bot_r;
  logic [7:0]     wall_r;
  logic [9:0]     h_cl;
  logic [9:0]     top_n;

  assign in_res = '{
    color:     in_color,
    height:    in_height,
    y_side:    in_y_side,
    column_id: in_column_id
  };

  result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (in_res),
    .pop   (pop),
    .dout  (head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign accept   = fb_we && fb_ready;
  assign last_acc = accept && (row == LAST);
  assign busy     = (f_count != '0) || (state != IDLE);

  assign h_cl  = (cur.height >= SH) ? SH : cur.height;
  assign top_n = (SH - h_cl) >> 1;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= nstate;
  end

  // FSM next-state logic.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (!f_empty) nstate = LOAD;
      LOAD: nstate = DRAW;
      DRAW: if (last_acc) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // FSM outputs: pop strobe and write request.
  always_comb begin
    pop  = 1'b0;
    draw = 1'b0;
    unique case (state)
      IDLE: pop = !f_empty;
      DRAW: draw = 1'b1;
      default: ;
    endcase
  end

  // Working result, strip geometry, row counter, flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur         <= '0;
      row         <= '0;
      top_r       <= '0;
      bot_r       <= '0;
      wall_r      <= '0;
      col_done    <= 1'b0;
      col_done_id <= '0;
      overflow    <= 1'b0;
    end else begin
      col_done <= 1'b0;
      if (in_valid && f_full)
        overflow <= 1'b1;
      if (pop)
        cur <= head;
      if (state == LOAD) begin
        top_r  <= top_n;
        bot_r  <= top_n + h_cl;
        wall_r <= cur.y_side ? {1'b0, cur.color[7:1]}
                             : cur.color;
        row    <= '0;
      end
      if (accept)
        row <= row + 1'b1;
      if (last_acc) begin
        col_done    <= 1'b1;
        col_done_id <= cur.column_id;
      end
    end
  end

  // Pixel presentation; zero outside DRAW.
  always_comb begin
    fb_we   = draw;
    fb_x    = '0;
    fb_y    = '0;
    fb_data = '0;
    if (draw) begin
      fb_x = cur.column_id;
      fb_y = row;
      if (row < top_r)
        fb_data = CEIL_COLOR;
      else if (row < bot_r)
        fb_data = wall_r;
      else
        fb_data = FLOOR_COLOR;
    end
  end

endmodule

// File: tb/tb_column_drawer.sv
// Scoreboard bench for column_drawer: stimulus queues
// expected writes, a monitor pops and compares them.
module tb_column_drawer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_color;
  logic [9:0] in_height;
  logic       in_y_side;
  logic [9:0] in_column_id;
  logic       fb_we;
  logic       fb_ready;
  logic [9:0] fb_x;
  logic [9:0] fb_y;
  logic [7:0] fb_data;
  logic       col_done;
  logic [9:0] col_done_id;
  logic       overflow;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int rdy_mode = 2;

  logic [27:0] exp_px [$];
  logic [9:0]  exp_done [$];

  column_drawer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_color     (in_color),
    .in_height    (in_height),
    .in_y_side    (in_y_side),
    .in_column_id (in_column_id),
    .fb_we        (fb_we),
    .fb_ready     (fb_ready),
    .fb_x         (fb_x),
    .fb_y         (fb_y),
    .fb_data      (fb_data),
    .col_done     (col_done),
    .col_done_id  (col_done_id),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Ready pattern: 0 always on, 1 random, 2 held low.
  initial begin
    fb_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1)
        fb_ready = 1'($urandom_range(0, 1));
      else
        fb_ready = (rdy_mode == 0);
    end
  end

  // Monitor: accepted writes, stall stability, completions.
  initial begin
    logic        stall;
    logic [27:0] held;
    logic [27:0] got;
    logic [27:0] want;
    stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      got = {fb_x, fb_y, fb_data};
      if (stall && rst_n) begin
        check("stall_we", int'(fb_we), 1);
        check("stall_hold", int'(got), int'(held));
      end
      stall = fb_we && !fb_ready;
      held = got;
      if (fb_we && fb_ready) begin
        if (exp_px.size() == 0) begin
          check("extra_write", int'(got), 0);
          tests--;
          fails++;
          tests++;
        end else begin
          want = exp_px.pop_front();
          check("pixel", int'(got), int'(want));
        end
      end
      if (col_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_done.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL col_done_unexp: got id %0d want none",
                   col_done_id);
        end else begin
          check("done_id", int'(col_done_id),
                int'(exp_done.pop_front()));
        end
      end
    end
  end

  // One input pulse; optionally queue the hand-computed strip.
  task automatic send(input logic [7:0] c, input logic [9:0] h,
                      input logic ys, input logic [9:0] col,
                      input int top, input int bot,
                      input logic [7:0] wp, input bit keep);
    in_valid = 1'b1;
    in_color = c;
    in_height = h;
    in_y_side = ys;
    in_column_id = col;
    if (keep) begin
      for (int y = 0; y < 600; y++) begin
        logic [7:0] d;
        d = (y < top) ? 8'h11 : (y < bot) ? wp : 8'h22;
        exp_px.push_back({col, 10'(y), d});
      end
      exp_done.push_back(col);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n;
    n = 0;
    while ((busy || exp_px.size() != 0 ||
            exp_done.size() != 0) && n < 8000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, int'(n < 8000), 1);
  endtask

  initial begin
    int t0;
    int n;
    int dc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_color = '0;
    in_height = '0;
    in_y_side = 1'b0;
    in_column_id = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", int'(fb_we), 0);
    check("rst_xyd", int'({fb_x, fb_y, fb_data}), 0);
    check("rst_done", int'({col_done, col_done_id}), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Basic strip with latency measurement.
    t0 = cyc;
    send(8'h2A, 10'd200, 1'b0, 10'd5, 200, 400, 8'h2A, 1);
    wait_drained("h200");
    check("latency", last_done_cyc - t0, 603);

    // Height boundaries and shading.
    send(8'h40, 10'd0, 1'b0, 10'd6, 300, 300, 8'h40, 1);
    wait_drained("h0");
    send(8'h2A, 10'd1023, 1'b0, 10'd7, 0, 600, 8'h2A, 1);
    wait_drained("h1023");
    send(8'h2A, 10'd1023, 1'b1, 10'd8, 0, 600, 8'h15, 1);
    wait_drained("yside");
    send(8'h33, 10'd201, 1'b1, 10'd9, 199, 400, 8'h19, 1);
    wait_drained("h201");
    send(8'h44, 10'd600, 1'b0, 10'd10, 0, 600, 8'h44, 1);
    wait_drained("h600");

    // Random backpressure, back-to-back columns.
    rdy_mode = 1;
    send(8'h5C, 10'd150, 1'b0, 10'd100, 225, 375, 8'h5C, 1);
    send(8'h5C, 10'd150, 1'b1, 10'd100, 225, 375, 8'h2E, 1);
    wait_drained("rand");
    rdy_mode = 0;
    check("ovf_clear", int'(overflow), 0);

    // Overflow: one drawing, four buffered, fifth dropped.
    send(8'h01, 10'd10, 1'b0, 10'd20, 295, 305, 8'h01, 1);
    repeat (4) @(posedge clk);
    #1;
    send(8'h02, 10'd20, 1'b0, 10'd21, 290, 310, 8'h02, 1);
    send(8'h03, 10'd30, 1'b0, 10'd22, 285, 315, 8'h03, 1);
    send(8'h04, 10'd40, 1'b0, 10'd23, 280, 320, 8'h04, 1);
    send(8'h05, 10'd50, 1'b0, 10'd24, 275, 325, 8'h05, 1);
    send(8'h06, 10'd60, 1'b0, 10'd25, 270, 330, 8'h06, 0);
    check("ovf_set", int'(overflow), 1);
    wait_drained("ovf");
    check("ovf_sticky", int'(overflow), 1);

    // Reset mid-draw at row 300.
    send(8'h77, 10'd100, 1'b0, 10'd30, 250, 350, 8'h77, 1);
    n = 0;
    @(negedge clk);
    while (!(fb_we && fb_y == 10'd300) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("row300_seen", int'(n < 2000), 1);
    dc = done_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_we", int'(fb_we), 0);
    check("mid_xyd", int'({fb_x, fb_y, fb_data}), 0);
    check("mid_done", int'({col_done, col_done_id}), 0);
    check("mid_ovf", int'(overflow), 0);
    check("mid_busy", int'(busy), 0);
    exp_px.delete();
    exp_done.delete();
    repeat (700) @(posedge clk);
    #1;
    check("mid_nodone", done_cnt, dc);
    check("mid_idle", int'({busy, fb_we}), 0);

    // Recovery after reset.
    send(8'h2A, 10'd200, 1'b0, 10'd31, 200, 400, 8'h2A, 1);
    wait_drained("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
